if_id_pipe_reg: RTL

- IF/ID pipeline register between instruction fetch and decode.
- Consumes the hazard unit's IF_ID_Write (hold) and flush (squash) controls.
- Captures instruction and PC+4 each cycle, tracks a valid bit, and presents decoded OpCode/Rs/Rt/Rd fields back to the hazard unit and control.
- Includes a consecutive-stall counter with a sticky watchdog flag for debug.

---
 rtl/if_id_pipe_reg.sv | 87 ++++++++
 1 files changed

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with hold/flush control, valid tracking, decoded fields and stall watchdog.
// Define IF_ID_PERF_EN to add the BubbleTotal/StallTotal performance counters.
module if_id_pipe_reg #(
  parameter int DATA_W    = 32,
  parameter int MAX_STALL = 15,
  parameter int CNT_W     = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [DATA_W-1:0] Instruction,
  input  logic [DATA_W-1:0] PCAddResult,
  input  logic              IF_ID_Write,
  input  logic              flush,
  output logic [DATA_W-1:0] IF_ID_Instruction,
  output logic [DATA_W-1:0] IF_ID_PCAddResult,
  output logic              IF_ID_Valid,
  output logic [5:0]        OpCode,
  output logic [4:0]        IF_ID_Rs,
  output logic [4:0]        IF_ID_Rt,
  output logic [4:0]        IF_ID_Rd,
  output logic [CNT_W-1:0]  StallCount,
`ifdef IF_ID_PERF_EN
  output logic [31:0]       BubbleTotal,
  output logic [31:0]       StallTotal,
`endif
  output logic              StallTimeout
);

  localparam logic [CNT_W-1:0] CNT_SAT   = '1;
  localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(MAX_STALL);

  logic             holdEdge;
  logic [CNT_W-1:0] stallInc;

  assign holdEdge = IF_ID_Write && !flush;
  assign stallInc = (StallCount == CNT_SAT) ? StallCount : StallCount + 1'b1;

  // Flush outranks hold: a held instruction is wrong-path once a branch is taken.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      IF_ID_Instruction <= '0;
      IF_ID_PCAddResult <= '0;
      IF_ID_Valid       <= 1'b0;
      StallCount        <= '0;
    end else if (flush) begin
      IF_ID_Instruction <= '0;
      IF_ID_PCAddResult <= PCAddResult;
      IF_ID_Valid       <= 1'b0;
      StallCount        <= '0;
    end else if (IF_ID_Write) begin
      StallCount        <= stallInc;
    end else begin
      IF_ID_Instruction <= Instruction;
      IF_ID_PCAddResult <= PCAddResult;
      IF_ID_Valid       <= 1'b1;
      StallCount        <= '0;
    end
  end

  // Sticky until reset so a debugger can see a past runaway stall.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      StallTimeout <= 1'b0;
    end else if (holdEdge && stallInc == STALL_LIM) begin
      StallTimeout <= 1'b1;
    end
  end

`ifdef IF_ID_PERF_EN
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      BubbleTotal <= '0;
      StallTotal  <= '0;
    end else begin
      if (flush)    BubbleTotal <= BubbleTotal + 32'd1;
      if (holdEdge) StallTotal  <= StallTotal + 32'd1;
    end
  end
`endif

  // Bubbles present zeroed fields so register-0 matches never look like real sources.
  assign OpCode   = IF_ID_Valid ? IF_ID_Instruction[31:26] : 6'd0;
  assign IF_ID_Rs = IF_ID_Valid ? IF_ID_Instruction[25:21] : 5'd0;
  assign IF_ID_Rt = IF_ID_Valid ? IF_ID_Instruction[20:16] : 5'd0;
  assign IF_ID_Rd = IF_ID_Valid ? IF_ID_Instruction[15:11] : 5'd0;

endmodule
